pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 32 +++
 rtl/pipe_stage_reg_if.sv | 11 +
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - stage control encoding and payload types for pipe_stage_reg
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HOLD      = 2'b01,
    FLUSH     = 2'b10,
    FLUSH_ALT = 2'b11
  } pipe_ctrl_t;

  localparam int WORD_W       = 32;
  localparam int WSEL_W       = 5;
  localparam int WSRC_W       = 2;
  localparam int MEMWB_DATA_W = 4 * WORD_W + WSEL_W + 2 + WSRC_W;

  // MEM/WB bundle packed into in_data by the MEM stage and unpacked by WB
  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] imm;
    logic [WSEL_W-1:0] wsel;
    logic              reg_write;
    logic              mem_read;
    logic [WSRC_W-1:0] write_src;
  } memwb_payload_t;

  function automatic logic is_flush(input pipe_ctrl_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready/data handshake bundle between pipeline stages
interface pipe_stage_reg_if import pipe_stage_reg_pkg::*; #(
  parameter int DATA_W = MEMWB_DATA_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/flush; PIPE_STAGE_SKID_EN adds a skid slot
module pipe_stage_reg import pipe_stage_reg_pkg::*; #(
  parameter int DATA_W         = MEMWB_DATA_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  pipe_ctrl_t        ctrl,
  pipe_stage_reg_if.slave   in_if,
  pipe_stage_reg_if.master  out_if,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic              in_ready;
  logic              run;
  logic              accept;
  logic              drain;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;

  // in_ready looks only at stored state and ctrl, never at out_ready
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    run      = (ctrl == RUN);
    in_ready = !RST && run && !skid_v_q;
    accept   = in_if.valid && in_ready;
    drain    = main_v_q && out_if.ready && run;
    if (is_flush(ctrl)) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d_d = '0;
        skid_d_d = '0;
      end
    end else if (drain) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d_d = skid_d_q;
        skid_v_d = accept;
        if (accept) skid_d_d = in_if.data;
      end else begin
        main_v_d = accept;
        if (accept) main_d_d = in_if.data;
      end
    end else if (accept) begin
      if (main_v_q) begin
        skid_v_d = 1'b1;
        skid_d_d = in_if.data;
      end else begin
        main_v_d = 1'b1;
        main_d_d = in_if.data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      skid_v_q <= 1'b0;
      skid_d_q <= CLEAR_ON_FLUSH ? '0 : skid_d_q;
    end else begin
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
`else
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    run      = (ctrl == RUN);
    in_ready = !RST && run && (!main_v_q || out_if.ready);
    accept   = in_if.valid && in_ready;
    drain    = main_v_q && out_if.ready && run;
    if (is_flush(ctrl)) begin
      main_v_d = 1'b0;
      if (CLEAR_ON_FLUSH) main_d_d = '0;
    end else if (accept) begin
      // covers accept-and-drain in one cycle: the new payload replaces main
      main_v_d = 1'b1;
      main_d_d = in_if.data;
    end else if (drain) begin
      main_v_d = 1'b0;
    end
  end

  assign occupancy = {1'b0, main_v_q};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_v_q <= 1'b0;
      main_d_q <= CLEAR_ON_FLUSH ? '0 : main_d_q;
    end else begin
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = main_v_q;
  assign out_if.data  = main_v_q ? main_d_q : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg (both PIPE_STAGE_SKID_EN builds)
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  pipe_ctrl_t ctrl = RUN;
  logic [1:0] occupancy;

  pipe_stage_reg_if #(.DATA_W(DW)) in_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) out_if ();

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ctrl      (ctrl),
    .in_if     (in_if),
    .out_if    (out_if),
    .occupancy (occupancy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    pipe_ctrl_t    ctrl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_irdy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input pipe_ctrl_t c, input logic iv, input logic [DW-1:0] id, input logic ordy,
                     input logic e_irdy, input logic e_ov, input logic [DW-1:0] e_od, input logic [1:0] e_occ);
    vec_t v;
    v.ctrl = c; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string nm, input int idx, input logic ov, input logic [DW-1:0] od, input logic [1:0] occ);
    chk({nm, ".out_valid"}, idx, 32'(out_if.valid), 32'(ov));
    chk({nm, ".out_data"},  idx, 32'(out_if.data),  32'(od));
    chk({nm, ".occupancy"}, idx, 32'(occupancy),    32'(occ));
  endtask

  initial begin
    in_if.valid  = 1'b1;
    in_if.data   = 8'hA5;
    out_if.ready = 1'b0;

    // reset held three cycles with a live input
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rst.in_ready", i, 32'(in_if.ready), 32'd0);
      check_out("rst", i, 1'b0, 8'h00, 2'd0);
    end
    in_if.valid = 1'b0;
    RST = 1'b0;
    #1;
    chk("rst.release_in_ready", 0, 32'(in_if.ready), 32'd1);

    // streaming 1..8, then drain
    for (int i = 1; i <= 8; i++) add(RUN, 1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 8'(i), 2'd1);
    add(RUN, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    // HOLD with main = 0x55
    add(RUN, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1);
    for (int i = 0; i < 4; i++) add(HOLD, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h55, 2'd1);
    add(RUN, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    // accept and drain in the same cycle at occupancy 1
    add(RUN, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 2'd1);
    add(RUN, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1);
    add(RUN, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
`ifdef PIPE_STAGE_SKID_EN
    // backpressure fills both slots; 3 waits until the skid frees
    add(RUN, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1);
    add(RUN, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2);
    add(RUN, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2);
    add(RUN, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1);
    add(RUN, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1);
    add(RUN, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    // flush from full
    add(RUN, 1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 8'h21, 2'd1);
    add(RUN, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h21, 2'd2);
    add(FLUSH, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
`else
    // single slot: out_ready gates in_ready combinationally
    add(RUN, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1);
    add(RUN, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 2'd1);
    add(RUN, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h02, 2'd1);
    add(RUN, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    add(RUN, 1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 8'h21, 2'd1);
    add(FLUSH, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
`endif
    add(RUN, 1'b1, 8'h31, 1'b0, 1'b1, 1'b1, 8'h31, 2'd1);
    add(FLUSH_ALT, 1'b1, 8'h32, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    add(RUN, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      ctrl         = vecs[i].ctrl;
      in_if.valid  = vecs[i].iv;
      in_if.data   = vecs[i].id;
      out_if.ready = vecs[i].ordy;
      #1;
      chk("vec.in_ready", i, 32'(in_if.ready), 32'(vecs[i].e_irdy));
      @(posedge CLK); #1;
      check_out("vec", i, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_occ);
    end

    // mid-stream reset wipes a held payload in one cycle
    ctrl = RUN; in_if.valid = 1'b1; in_if.data = 8'h3C; out_if.ready = 1'b0;
    @(posedge CLK); #1;
    check_out("midrst.fill", 0, 1'b1, 8'h3C, 2'd1);
    RST = 1'b1; in_if.data = 8'h3D;
    #1;
    chk("midrst.in_ready", 0, 32'(in_if.ready), 32'd0);
    @(posedge CLK); #1;
    check_out("midrst", 0, 1'b0, 8'h00, 2'd0);
    RST = 1'b0; in_if.valid = 1'b0;
    #1;
    chk("midrst.release_in_ready", 0, 32'(in_if.ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
